// File: rtl/des_iter_ctrl.sv
// Iterative DES round sequencer: latches block/key/mode, runs 16 Feistel rounds
// (one per clock) through an external f-function and returns the permuted result.
module des_iter_ctrl #(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned KEY_WIDTH    = 64,
   parameter int unsigned SUBKEY_WIDTH = 48,
   parameter int unsigned ROUNDS       = 16
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [DATA_WIDTH-1:0]                 in_data,
   input  logic [KEY_WIDTH-1:0]                  in_key,
   input  logic                                  in_encrypt,
   output logic [KEY_WIDTH-1:0]                  ks_key,
   output logic                                  ks_encryption_en,
   input  logic [ROUNDS-1:0][SUBKEY_WIDTH-1:0]   ks_subkey,
   output logic [DATA_WIDTH/2-1:0]               f_r,
   output logic [SUBKEY_WIDTH-1:0]               f_subkey,
   input  logic [DATA_WIDTH/2-1:0]               f_out,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [DATA_WIDTH-1:0]                 out_data,
   output logic                                  busy,
   output logic [$clog2(ROUNDS)-1:0]             round_idx
);

   localparam int unsigned HALF = DATA_WIDTH / 2;
   localparam int unsigned RW   = $clog2(ROUNDS);

   // FIPS 46-3 tables; entry i gives the 1-based source bit for output DES bit i+1
   localparam int unsigned IP_TAB [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2,
      60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,
      64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1,
      59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,
      63, 55, 47, 39, 31, 23, 15, 7
   };

   localparam int unsigned FP_TAB [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32,
      39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30,
      37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28,
      35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26,
      33, 1, 41,  9, 49, 17, 57, 25
   };

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // DES bit n lives at vector bit 64-n
   function automatic logic [DATA_WIDTH-1:0] apply_ip(input logic [DATA_WIDTH-1:0] din);
      logic [DATA_WIDTH-1:0] dout;
      dout = '0;
      for (int i = 0; i < 64; i++) begin
         dout[6'(63 - i)] = din[6'(64 - IP_TAB[6'(i)])];
      end
      return dout;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] apply_fp(input logic [DATA_WIDTH-1:0] din);
      logic [DATA_WIDTH-1:0] dout;
      dout = '0;
      for (int i = 0; i < 64; i++) begin
         dout[6'(63 - i)] = din[6'(64 - FP_TAB[6'(i)])];
      end
      return dout;
   endfunction

   state_e                  state_q, state_d;
   logic [KEY_WIDTH-1:0]    key_q, key_d;
   logic                    mode_q, mode_d;
   logic [HALF-1:0]         l_q, l_d;
   logic [HALF-1:0]         r_q, r_d;
   logic [RW-1:0]           round_q, round_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic                    busy_q, busy_d;

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      mode_d     = mode_q;
      l_d        = l_q;
      r_d        = r_q;
      round_d    = round_q;
      out_data_d = out_data_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               key_d      = in_key;
               mode_d     = in_encrypt;
               {l_d, r_d} = apply_ip(in_data);
               round_d    = '0;
               state_d    = ST_ROUND;
            end
         end
         ST_ROUND: begin
            l_d     = r_q;
            r_d     = l_q ^ f_out;
            round_d = round_q + RW'(1);
            // Final round skips the swap: pre-output is R16||L16
            if (round_q == RW'(ROUNDS - 1)) begin
               out_data_d = apply_fp({l_q ^ f_out, r_q});
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         key_q       <= '0;
         mode_q      <= 1'b0;
         l_q         <= '0;
         r_q         <= '0;
         round_q     <= '0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         mode_q      <= mode_d;
         l_q         <= l_d;
         r_q         <= r_d;
         round_q     <= round_d;
         out_data_q  <= out_data_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready         = in_ready_q;
   assign out_valid        = out_valid_q;
   assign busy             = busy_q;
   assign out_data         = out_data_q;
   assign round_idx        = round_q;
   assign ks_key           = key_q;
   assign ks_encryption_en = mode_q;
   assign f_r              = r_q;
   assign f_subkey         = ks_subkey[round_q];

endmodule
